montgomery_radix_serial: RTL and testbench

- Digit-serial Montgomery modular multiplier; parametrised successor of the bit-serial montgomery_serialized core.
- Processes DIGIT_WIDTH bits of x per cycle (radix 2^DIGIT_WIDTH) over a runtime modulus of up to DATA_LENGTH bits.
- Adds a ready/busy handshake, an error flag and fixed, data-independent latency.
- Sits in the arithmetic datapath (Dilithium NTT/pointwise stages) wherever x*y mod m is needed with y supplied in Montgomery form.

---
 rtl/montgomery_radix_serial_pkg.sv | 28 ++
 rtl/montgomery_radix_serial_digit_step.sv | 26 ++
 rtl/montgomery_radix_serial.sv | 145 ++++++++++++++
 tb/tb_montgomery_radix_serial.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/montgomery_radix_serial_pkg.sv
// Shared constants, FSM state type and iteration-count helper for the
// digit-serial Montgomery multiplier.
package montgomery_radix_serial_pkg;

  localparam int unsigned DATA_LENGTH_DEFAULT = 64;
  localparam int unsigned DIGIT_WIDTH_DEFAULT = 1;

  // Dilithium modulus q = 2^23 - 2^13 + 1 and -q^-1 mod 2^w for each radix
  localparam int unsigned MODULUS          = 8380417;
  localparam int unsigned MODULUS_LENGTH   = 23;
  localparam int unsigned MODULUS_PRIME_R2 = 1;
  localparam int unsigned MODULUS_PRIME_R4 = 3;
  localparam int unsigned MODULUS_PRIME_R16 = 15;
  localparam int unsigned MODULUS_PRIME_R256 = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2
  } state_t;

  // Number of digit iterations: ceil(bit_len / digit_width)
  function automatic int unsigned iter_count(input int unsigned bit_len,
                                             input int unsigned digit_width);
    return (bit_len + digit_width - 1) / digit_width;
  endfunction

endpackage

// File: rtl/montgomery_radix_serial_digit_step.sv
// One radix-2^DIGIT_WIDTH Montgomery iteration: A_next = (A + d*y + q*m) >> DIGIT_WIDTH.
module montgomery_radix_serial_digit_step #(
  parameter int unsigned DATA_LENGTH = 64,
  parameter int unsigned DIGIT_WIDTH = 1
) (
  input  logic [DATA_LENGTH:0]   i_a,
  input  logic [DIGIT_WIDTH-1:0] i_d,
  input  logic [DATA_LENGTH-1:0] i_y,
  input  logic [DATA_LENGTH-1:0] i_m,
  input  logic [DIGIT_WIDTH-1:0] i_m_prime,
  output logic [DATA_LENGTH:0]   o_a_next
);

  localparam int unsigned TW = DATA_LENGTH + DIGIT_WIDTH + 1;

  logic [TW-1:0]          w_t;
  logic [TW-1:0]          w_u;
  logic [DIGIT_WIDTH-1:0] w_q;

  assign w_t = TW'(i_a) + TW'(i_d) * TW'(i_y);
  // q chosen so the low digit of T + q*m is zero and the shift is exact
  assign w_q = w_t[DIGIT_WIDTH-1:0] * i_m_prime;
  assign w_u = w_t + TW'(w_q) * TW'(i_m);
  assign o_a_next = w_u[TW-1:DIGIT_WIDTH];

endmodule

// File: rtl/montgomery_radix_serial.sv
// Digit-serial Montgomery multiplier: result = x*y*R^-1 mod m with
// R = 2^(N*DIGIT_WIDTH), fixed latency of N+1 cycles after acceptance.
module montgomery_radix_serial
  import montgomery_radix_serial_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = DATA_LENGTH_DEFAULT,
  parameter int unsigned DIGIT_WIDTH = DIGIT_WIDTH_DEFAULT
) (
  input  logic                   CLK_pci_sys_clk_p,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] y_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  input  logic [DIGIT_WIDTH-1:0] m_prime_i,
  output logic                   ready_o,
  output logic                   busy_o,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
  output logic                   err_o
);

  localparam int unsigned CW = $clog2(DATA_LENGTH / DIGIT_WIDTH + 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_accept;
  logic                   w_param_err;
  logic [CW-1:0]          w_n;

  logic [DATA_LENGTH-1:0] r_x;
  logic [DATA_LENGTH-1:0] r_y;
  logic [DATA_LENGTH-1:0] r_m;
  logic [DIGIT_WIDTH-1:0] r_m_prime;
  logic [CW-1:0]          r_n;
  logic [CW-1:0]          r_cnt;
  logic [DATA_LENGTH:0]   r_a;
  logic                   r_err_pend;
  logic [DATA_LENGTH:0]   w_a_next;
  logic [DATA_LENGTH:0]   w_m_ext;

  logic                   r_ready;
  logic                   r_busy;
  logic [DATA_LENGTH-1:0] r_result;
  logic                   r_valid;
  logic                   r_err;

  assign w_n     = CW'(iter_count(32'(m_bl_i), DIGIT_WIDTH));
  assign w_m_ext = {1'b0, r_m};

  montgomery_radix_serial_digit_step #(
    .DATA_LENGTH(DATA_LENGTH),
    .DIGIT_WIDTH(DIGIT_WIDTH)
  ) u_step (
    .i_a      (r_a),
    .i_d      (r_x[DIGIT_WIDTH-1:0]),
    .i_y      (r_y),
    .i_m      (r_m),
    .i_m_prime(r_m_prime),
    .o_a_next (w_a_next)
  );

  always_ff @(posedge CLK_pci_sys_clk_p) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_param_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_accept     = 1'b1;
          w_param_err  = !m_i[0] || (m_bl_i == '0) ||
                         (m_bl_i > DATA_LENGTH'(DATA_LENGTH));
          w_next_state = w_param_err ? FINAL : ITER;
        end
      end
      ITER:    if (r_cnt == r_n - CW'(1)) w_next_state = FINAL;
      FINAL:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture, digit iteration and final conditional subtraction
  always_ff @(posedge CLK_pci_sys_clk_p) begin
    if (rst_i) begin
      r_x        <= '0;
      r_y        <= '0;
      r_m        <= '0;
      r_m_prime  <= '0;
      r_n        <= '0;
      r_cnt      <= '0;
      r_a        <= '0;
      r_err_pend <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ready <= (w_next_state == IDLE);
      r_busy  <= (w_next_state != IDLE);
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x        <= x_i;
            r_y        <= y_i;
            r_m        <= m_i;
            r_m_prime  <= m_prime_i;
            r_n        <= w_n;
            r_cnt      <= '0;
            r_a        <= '0;
            r_err_pend <= w_param_err;
          end
        end
        ITER: begin
          r_a   <= w_a_next;
          r_x   <= r_x >> DIGIT_WIDTH;
          r_cnt <= r_cnt + CW'(1);
        end
        FINAL: begin
          r_valid <= 1'b1;
          r_err   <= r_err_pend;
          if (r_err_pend)          r_result <= '0;
          else if (r_a >= w_m_ext) r_result <= DATA_LENGTH'(r_a - w_m_ext);
          else                     r_result <= DATA_LENGTH'(r_a);
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = r_ready;
  assign busy_o   = r_busy;
  assign result_o = r_result;
  assign valid_o  = r_valid;
  assign err_o    = r_err;

endmodule

// File: tb/tb_montgomery_radix_serial.sv
// Bench for montgomery_radix_serial: radix-2 and radix-4 instances checked
// against a bit-by-bit modular-halving reference.
module tb_montgomery_radix_serial;

  localparam int unsigned DL = 32;

  logic          clk;
  logic          rst   [2];
  logic          start [2];
  logic [DL-1:0] x     [2];
  logic [DL-1:0] y     [2];
  logic [DL-1:0] m     [2];
  logic [DL-1:0] mbl   [2];
  logic [1:0]    mp    [2];
  logic          ready [2];
  logic          busy  [2];
  logic [DL-1:0] res   [2];
  logic          valid [2];
  logic          err   [2];

  int errors = 0;
  int checks = 0;

  montgomery_radix_serial #(.DATA_LENGTH(DL), .DIGIT_WIDTH(1)) u_dut_r2 (
    .CLK_pci_sys_clk_p(clk), .rst_i(rst[0]), .start_i(start[0]),
    .x_i(x[0]), .y_i(y[0]), .m_i(m[0]), .m_bl_i(mbl[0]), .m_prime_i(mp[0][0:0]),
    .ready_o(ready[0]), .busy_o(busy[0]), .result_o(res[0]),
    .valid_o(valid[0]), .err_o(err[0]));

  montgomery_radix_serial #(.DATA_LENGTH(DL), .DIGIT_WIDTH(2)) u_dut_r4 (
    .CLK_pci_sys_clk_p(clk), .rst_i(rst[1]), .start_i(start[1]),
    .x_i(x[1]), .y_i(y[1]), .m_i(m[1]), .m_bl_i(mbl[1]), .m_prime_i(mp[1]),
    .ready_o(ready[1]), .busy_o(busy[1]), .result_o(res[1]),
    .valid_o(valid[1]), .err_o(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dw_of(input int s);
    return (s == 0) ? 1 : 2;
  endfunction

  // x*y*2^-(N*dw) mod m by repeated halving modulo m
  function automatic logic [DL-1:0] mont_ref(input logic [DL-1:0] xx, yy, mm, mb,
                                             input int dw);
    logic [63:0] t;
    int n;
    n = (int'(mb) + dw - 1) / dw;
    t = (64'(xx) * 64'(yy)) % 64'(mm);
    for (int k = 0; k < n * dw; k++) begin
      if (t[0]) t = t + 64'(mm);
      t = t >> 1;
    end
    return DL'(t);
  endfunction

  function automatic logic [1:0] mprime_of(input logic [DL-1:0] mm, input int dw);
    for (int q = 0; q < (1 << dw); q++)
      if (((64'(mm) * 64'(q) + 64'd1) % (64'd1 << dw)) == 64'd0) return 2'(q);
    return 2'd0;
  endfunction

  function automatic int lat_of(input logic [DL-1:0] mb, input int dw);
    return (int'(mb) + dw - 1) / dw + 1;
  endfunction

  task automatic load(input int s, input logic [DL-1:0] xx, yy, mm, mb,
                      input logic [1:0] mpv);
    x[s] = xx; y[s] = yy; m[s] = mm; mbl[s] = mb; mp[s] = mpv;
  endtask

  task automatic start_op(input int s, input logic [DL-1:0] xx, yy, mm, mb,
                          input logic [1:0] mpv);
    @(negedge clk);
    load(s, xx, yy, mm, mb, mpv);
    start[s] = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
  endtask

  // Called #1 after an edge; counts edges until valid, busy samples before it
  task automatic wait_valid(input int s, output int edges, output int busy_cnt,
                            output logic [DL-1:0] r, output logic e, output bit to);
    edges = 0; busy_cnt = 0; to = 1'b1; r = '0; e = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (busy[s]) busy_cnt++;
      @(posedge clk); #1;
      edges++;
      if (valid[s]) begin
        r = res[s]; e = err[s]; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 2; s++) rst[s] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (ready[s] !== 1'b1 || busy[s] !== 1'b0 || valid[s] !== 1'b0 ||
          err[s] !== 1'b0 || res[s] !== '0) begin
        errors++;
        $display("FAIL reset[%0d]: ready=%b busy=%b valid=%b err=%b res=%0d, want 1 0 0 0 0",
                 s, ready[s], busy[s], valid[s], err[s], res[s]);
      end
    end
    @(negedge clk);
    for (int s = 0; s < 2; s++) rst[s] = 1'b0;
  endtask

  task automatic check_op(input string name, input int s, input logic [DL-1:0] xx, yy,
                          mm, mb, input logic [DL-1:0] want, input int want_busy);
    int edges, bc; logic [DL-1:0] r; logic e; bit to;
    start_op(s, xx, yy, mm, mb, mprime_of(mm, dw_of(s)));
    wait_valid(s, edges, bc, r, e, to);
    checks++;
    if (to || r !== want || e !== 1'b0) begin
      errors++;
      $display("FAIL %s: timeout=%0d result=%0d err=%b, want result=%0d err=0",
               name, to, r, e, want);
    end
    checks++;
    if (edges != lat_of(mb, dw_of(s))) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, want %0d", name, edges, lat_of(mb, dw_of(s)));
    end
    if (want_busy > 0) begin
      checks++;
      if (bc != want_busy) begin
        errors++;
        $display("FAIL %s busy cycles: got %0d, want %0d", name, bc, want_busy);
      end
    end
  endtask

  task automatic test_known_vectors;
    check_op("r2_m13", 0, 5, 8, 13, 4, 9, 5);
    check_op("r2_dil_a", 0, 1, 8191, 8380417, 23, 1, 0);
    check_op("r2_dil_b", 0, 8380416, 8372226, 8380417, 23, 1, 0);
    check_op("r4_m13", 1, 5, 8, 13, 4, 9, 3);
    check_op("r4_x0", 1, 0, 8, 13, 4, 0, 0);
  endtask

  task automatic test_error;
    int edges, bc; logic [DL-1:0] r; logic e; bit to;
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        if (c == 0) start_op(s, 5, 8, 12, 4, 2'd1);
        else        start_op(s, 5, 8, 13, 0, 2'd1);
        wait_valid(s, edges, bc, r, e, to);
        checks++;
        if (to || e !== 1'b1 || r !== '0 || edges != 1) begin
          errors++;
          $display("FAIL error[%0d,%0d]: timeout=%0d err=%b result=%0d edges=%0d, want err=1 result=0 edges=1",
                   s, c, to, e, r, edges);
        end
        @(posedge clk); #1;
        checks++;
        if (valid[s] !== 1'b0 || err[s] !== 1'b0) begin
          errors++;
          $display("FAIL error_pulse[%0d,%0d]: valid=%b err=%b, want 0 0", s, c, valid[s], err[s]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int edges, bc, extra; logic [DL-1:0] r; logic e; bit to;
    start_op(0, 5, 8, 13, 4, 2'd1);
    wait_valid(0, edges, bc, r, e, to);
    checks++;
    if (to || ready[0] !== 1'b1 || r !== 9) begin
      errors++;
      $display("FAIL b2b_first: timeout=%0d ready=%b result=%0d, want ready=1 result=9", to, ready[0], r);
    end
    load(0, 7, 3, 13, 4, 2'd1);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_valid(0, edges, bc, r, e, to);
    checks++;
    if (to || r !== mont_ref(7, 3, 13, 4, 1) || edges != 5) begin
      errors++;
      $display("FAIL b2b_second: timeout=%0d result=%0d edges=%0d, want result=%0d edges=5",
               to, r, edges, mont_ref(7, 3, 13, 4, 1));
    end
    extra = 0;
    repeat (10) begin @(posedge clk); #1; if (valid[0]) extra++; end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL b2b_extra_valid: got %0d pulses, want 0", extra);
    end
  endtask

  task automatic test_start_while_busy;
    int edges, bc, extra; logic [DL-1:0] r; logic e; bit to;
    start_op(1, 11, 6, 13, 4, 2'd3);
    @(negedge clk);
    load(1, 2, 9, 13, 4, 2'd3);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    #6;
    wait_valid(1, edges, bc, r, e, to);
    checks++;
    if (to || r !== mont_ref(11, 6, 13, 4, 2)) begin
      errors++;
      $display("FAIL busy_ignore: timeout=%0d result=%0d, want %0d", to, r, mont_ref(11, 6, 13, 4, 2));
    end
    extra = 0;
    repeat (20) begin @(posedge clk); #1; if (valid[1]) extra++; end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_ignore_extra_valid: got %0d pulses, want 0", extra);
    end
  endtask

  task automatic test_mid_reset;
    int extra;
    start_op(0, 1, 8191, 8380417, 23, 2'd1);
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    checks++;
    if (ready[0] !== 1'b1 || busy[0] !== 1'b0 || res[0] !== '0 || valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b busy=%b result=%0d valid=%b, want 1 0 0 0",
               ready[0], busy[0], res[0], valid[0]);
    end
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (valid[0]) extra++; end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL mid_reset_valid: got %0d pulses, want 0", extra);
    end
  endtask

  task automatic test_random;
    logic [63:0] mask;
    logic [DL-1:0] mm, xx, yy, mb;
    int bl;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 25; k++) begin
        bl   = int'($urandom_range(2, 31));
        mask = (64'd1 << bl) - 64'd1;
        mm   = DL'((64'($urandom) | (64'd1 << (bl - 1)) | 64'd1) & mask);
        xx   = DL'(64'($urandom) % 64'(mm));
        yy   = DL'(64'($urandom) % 64'(mm));
        mb   = DL'(bl + int'($urandom_range(0, 1)));
        check_op("random", s, xx, yy, mm, mb, mont_ref(xx, yy, mm, mb, dw_of(s)), 0);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; start[s] = 1'b0;
      load(s, '0, '0, '0, '0, 2'd0);
    end
    test_reset();
    test_known_vectors();
    test_error();
    test_back_to_back();
    test_start_while_busy();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
